// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : nibble_serial_add_ctrl_pkg

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester-side start/busy/done handshake plus operand and result buses.
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );

endinterface : nibble_serial_add_ctrl_if

// File: rtl/nibble_serial_add_ctrl_four_bit.sv
// Existing 4-bit ripple-carry adder slice, shared across all nibbles.
module four_bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4
);

    logic c1, c2, c3;

    assign S[0] = A[0] ^ B[0] ^ C0;
    assign c1   = (A[0] & B[0]) | (C0 & (A[0] ^ B[0]));
    assign S[1] = A[1] ^ B[1] ^ c1;
    assign c2   = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
    assign S[2] = A[2] ^ B[2] ^ c2;
    assign c3   = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
    assign S[3] = A[3] ^ B[3] ^ c3;
    assign C4   = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));

endmodule : four_bit

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer adding/subtracting WIDTH-bit operands through one shared 4-bit
// adder slice, LSB nibble first, one nibble per clock.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  bus
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = $clog2(NIBBLES);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               carry_q, carry_d;
    logic               amsb_q, amsb_d;
    logic               bmsb_q, bmsb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c4;
    logic [WIDTH-1:0]    result;

    four_bit u_slice (
        .A  (opa_q[NIBBLE_W-1:0]),
        .B  (opb_q[NIBBLE_W-1:0]),
        .C0 (carry_q),
        .S  (slice_s),
        .C4 (slice_c4)
    );

    // The final nibble lands on top; earlier nibbles have already shifted down.
    assign result = {slice_s, part_q[WIDTH-1:NIBBLE_W]};

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        carry_d = carry_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = opb_d[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> NIBBLE_W;
                opb_d   = opb_q >> NIBBLE_W;
                part_d  = result;
                carry_d = slice_c4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    sum_d   = result;
                    cout_d  = slice_c4;
                    ovf_d   = (amsb_q ^ bmsb_q ^ result[WIDTH-1]) ^ slice_c4;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule : nibble_serial_add_ctrl

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed results, a monitor checks
// them whenever done pulses.
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_done = -1;
    int           prev_done = -1;
    int           tag = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
                e = sb.pop_front();
                check($sformatf("sum_op%0d", e.tag), 32'(bus.sum), 32'(e.sum));
                check($sformatf("cout_op%0d", e.tag), 32'(bus.cout), 32'(e.cout));
                check($sformatf("ovf_op%0d", e.tag), 32'(bus.overflow), 32'(e.ovf));
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb_i, input logic [W-1:0] es, input logic ec,
                          input logic eo, input bit pulse_mid);
        int n;
        int nb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.sub   = sb_i;
        sb.push_back('{sum: es, cout: ec, ovf: eo, tag: tag});
        tag++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~ci;
        bus.sub   = ~sb_i;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("result_hold", 32'({bus.sum, bus.cout, bus.overflow}),
              32'({prev_sum, prev_cout, prev_ovf}));
        n  = 0;
        nb = 1;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) nb++;
            if (pulse_mid) begin
                bus.start = (n == 1);
                bus.a     = 16'hFFFF;
                bus.b     = 16'hFFFF;
                bus.sub   = 1'b1;
            end
        end
        bus.start = 1'b0;
        check("done_latency", 32'(n), 32'(NIB));
        check("busy_cycles", 32'(nb), 32'(NIB));
        prev_sum  = es;
        prev_cout = ec;
        prev_ovf  = eo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        idle_cycle();
        run_op(16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        idle_cycle();

        // start pulsed mid-RUN with other operands must not disturb the result
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        idle_cycle();

        // back-to-back: second start lands in the DONE cycle
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_op(16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("done_spacing", 32'(last_done - prev_done), 32'd5);
        idle_cycle();

        // abort during the second RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0101;
        bus.b     = 16'h0202;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) n++;
        end
        check("no_done_after_abort", 32'(n), 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;

        run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0);
        repeat (3) idle_cycle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_add_ctrl
